carryadder_chain: RTL
=====================

# carryadder_chain

Multi-byte addition sequencer acting as the initiator for the 8-bit carry adder's rx/tx interface. Accepts a BYTES-wide add command, issues one 8-bit add per byte (LSB first) to the adder, chains the carry, collects sums and flags, and returns one wide result through a valid/ready handshake. It sits between the datapath command source and an instance of `carryadder8`.

## Interface
- BYTES, 4, operand width in bytes (N = 8*BYTES); must be ≥ 1
- TIMEOUT, 16, WAIT-state cycles allowed before abort (only used with the timeout macro)
- aclk  in  1  sole clock, rising edge
- aresetn  in  1  reset, asynchronous assert, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block can accept a command
- cmd_a  in  N  addend A
- cmd_b  in  N  addend B
- cmd_carryin  in  1  carry into byte 0
- res_valid  out  1  result available
- res_ready  in  1  result consumer ready
- res_sum  out  N  wide sum
- res_carry  out  1  carry out of the top byte
- res_zero  out  1  1 when every byte sum was zero
- res_error  out  1  adder timeout abort
- rx_enable  out  1  to adder: transaction active
- rx_write  out  1  to adder: write/launch qualifier
- rx_strobe  out  1  to adder: one-cycle launch pulse
- rx_carryflag  out  1  to adder: carry in for this byte
- rx_addend0  out  8  to adder: byte of A
- rx_addend1  out  8  to adder: byte of B
- tx_sum  in  8  from adder: byte sum
- tx_carryflag  in  1  from adder: byte carry out
- tx_zeroflag  in  1  from adder: byte sum zero
- tx_ready  in  1  from adder: byte result valid

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: cmd_ready=1. On cmd_valid: capture cmd_a/cmd_b, carry←cmd_carryin, idx←0, zero_acc←1, sum register←0, error←0; go ISSUE.
- ISSUE (one cycle): rx_enable=1, rx_write=1, rx_strobe=1, rx_addend0=A[idx], rx_addend1=B[idx], rx_carryflag=carry; go WAIT. tx_ready ignored in ISSUE.
- WAIT: rx_enable=1, rx_write=0, rx_strobe=0; rx_addend0/1 and rx_carryflag held at ISSUE values. On tx_ready: sum byte[idx]←tx_sum, carry←tx_carryflag, zero_acc←zero_acc & tx_zeroflag; if idx==BYTES-1 go DONE, else idx+1, go ISSUE.
- DONE: res_valid=1; res_sum/res_carry/res_zero/res_error stable until handshake; on res_ready go IDLE. cmd_ready=0 in ISSUE, WAIT, DONE.
- res_carry = last captured tx_carryflag; res_zero = zero_acc; no arithmetic is performed locally.
- Exactly one strobe per byte; no strobe outside ISSUE.

## Timing
- Reset: state IDLE; cmd_ready=1; res_valid, res_sum, res_carry, res_zero, res_error, rx_enable, rx_write, rx_strobe, rx_carryflag, rx_addend0, rx_addend1 all 0.
- Reset mid-operation: transaction abandoned, no result produced, outputs return to reset values immediately (async).
- Per byte: 1 ISSUE cycle + WAIT cycles until tx_ready. With tx_ready in the cycle after strobe: res_valid rises 2*BYTES+1 cycles after the accepting edge (9 for BYTES=4).
- Command accepted on the edge where cmd_valid & cmd_ready; result retired on the edge where res_valid & res_ready; earliest next acceptance is the cycle after retirement (no overlap).
- tx_ready held high across multiple WAIT cycles counts once; state leaves WAIT on the first edge.

## Configuration
- CARRYADDER_CHAIN_TIMEOUT_EN defined: a counter runs in WAIT, cleared on entry; reaching TIMEOUT cycles without tx_ready sets error←1, zero_acc←0, go DONE (res_sum holds completed bytes, others 0; res_carry = last chained carry).
- Not defined: no counter; WAIT waits indefinitely; res_error tied 0.

## Test plan
- BYTES=4, A=0x000000FF, B=0x00000001, cin=0 -> res_sum=0x00000100, res_carry=0, res_zero=0, res_valid 9 cycles after accept.
- A=0xFFFFFFFF, B=0x00000001, cin=0 -> res_sum=0x00000000, res_carry=1, res_zero=1; rx_carryflag=1 on strobes for bytes 1–3.
- A=0x12345678, B=0x11111111, cin=1 -> res_sum=0x2345678A, res_carry=0; exactly 4 rx_strobe pulses with addend bytes 0x78/0x11, 0x56/0x11, 0x34/0x11, 0x12/0x11.
- Adder delays tx_ready 3 cycles per byte, res_ready low 5 cycles in DONE -> correct sum, addends stable through WAIT, result stable, cmd_ready=0 and cmd_valid ignored until retirement.
- aresetn pulsed low during WAIT of byte 2 -> all outputs at reset values, no res_valid; next command completes correctly.
- With CARRYADDER_CHAIN_TIMEOUT_EN, TIMEOUT=16, tx_ready never asserted -> res_valid with res_error=1, res_zero=0, res_sum=0 after 16 WAIT cycles; without macro, res_valid stays 0.

Source files
------------

// File: rtl/carryadder_chain.sv
// carryadder_chain: multi-byte add sequencer driving an 8-bit carry adder.
// A BYTES-wide command is split into byte adds, LSB first. The carry is
// chained through the adder, and the byte sums and flags are collected into
// one wide result that is returned over a valid/ready handshake.
// Optional feature: define CARRYADDER_CHAIN_TIMEOUT_EN to abort a byte whose
// tx_ready does not arrive within TIMEOUT WAIT cycles. The result is then
// flagged through res_error.
module carryadder_chain #(
    parameter int BYTES   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    // command side
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [8*BYTES-1:0]   cmd_a,
    input  logic [8*BYTES-1:0]   cmd_b,
    input  logic                 cmd_carryin,
    // result side
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [8*BYTES-1:0]   res_sum,
    output logic                 res_carry,
    output logic                 res_zero,
    output logic                 res_error,
    // adder request side
    output logic                 rx_enable,
    output logic                 rx_write,
    output logic                 rx_strobe,
    output logic                 rx_carryflag,
    output logic [7:0]           rx_addend0,
    output logic [7:0]           rx_addend1,
    // adder response side
    input  logic [7:0]           tx_sum,
    input  logic                 tx_carryflag,
    input  logic                 tx_zeroflag,
    input  logic                 tx_ready
);

    localparam int N     = 8 * BYTES;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [N-1:0]     a_q;
    logic [N-1:0]     b_q;
    logic [N-1:0]     sum_q;
    logic             carry_q;
    logic             zero_q;
    logic [IDX_W-1:0] idx_q;
    logic             valid_q;

    logic             accept;
    logic             last_byte;
    logic             timeout_hit;
    logic             active;
    logic [7:0]       a_byte;
    logic [7:0]       b_byte;

    assign accept    = (state == S_IDLE) && cmd_valid;
    assign last_byte = (idx_q == IDX_W'(BYTES - 1));
    assign a_byte    = a_q[{idx_q, 3'b000} +: 8];
    assign b_byte    = b_q[{idx_q, 3'b000} +: 8];

`ifdef CARRYADDER_CHAIN_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             error_q;

    // WAIT-cycle counter. It is held at zero outside WAIT, so it restarts for every byte.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wait_cnt <= '0;
        end else if (state != S_WAIT) begin
            wait_cnt <= '0;
        end else if (!tx_ready) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // The abort fires on the last allowed WAIT cycle, and only if tx_ready is still absent.
    assign timeout_hit = (state == S_WAIT) && !tx_ready
                         && (wait_cnt == CNT_W'(TIMEOUT - 1));

    // Error flag: cleared when a command is accepted, set when a byte is aborted.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            error_q <= 1'b0;
        end else if (accept) begin
            error_q <= 1'b0;
        end else if (timeout_hit) begin
            error_q <= 1'b1;
        end
    end

    assign res_error = error_q;
`else
    assign timeout_hit = 1'b0;
    assign res_error   = 1'b0;
`endif

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: ISSUE lasts one cycle, and WAIT leaves on the first tx_ready.
    always_comb begin
        // NOTE: default first, so no path through the case leaves state_next unassigned (no latch).
        state_next = state;
        case (state)
            S_IDLE:  if (cmd_valid) state_next = S_ISSUE;
            S_ISSUE: state_next = S_WAIT;
            S_WAIT: begin
                if (tx_ready) begin
                    state_next = last_byte ? S_DONE : S_ISSUE;
                end else if (timeout_hit) begin
                    state_next = S_DONE;
                end
            end
            S_DONE:  if (valid_q && res_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Operand capture, byte-result collection and carry/zero chaining.
    // NOTE: operand and result registers all reset, so no stale command is ever visible.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        a_q     <= cmd_a;
                        b_q     <= cmd_b;
                        sum_q   <= '0;
                        carry_q <= cmd_carryin;
                        zero_q  <= 1'b1;
                        idx_q   <= '0;
                    end
                end
                S_WAIT: begin
                    if (tx_ready) begin
                        sum_q[{idx_q, 3'b000} +: 8] <= tx_sum;
                        carry_q <= tx_carryflag;
                        zero_q  <= zero_q & tx_zeroflag;
                        if (!last_byte) idx_q <= idx_q + 1'b1;
                    end else if (timeout_hit) begin
                        zero_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Result-valid flop. The wide result settles for one DONE cycle and is then presented from a register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= (state == S_DONE) && !(valid_q && res_ready);
        end
    end

    // Output decode: adder request signals are driven only while a byte is in flight.
    always_comb begin
        active       = (state == S_ISSUE) || (state == S_WAIT);
        cmd_ready    = (state == S_IDLE);
        rx_enable    = active;
        rx_write     = (state == S_ISSUE);
        rx_strobe    = (state == S_ISSUE);
        rx_carryflag = active & carry_q;
        rx_addend0   = active ? a_byte : 8'h00;
        rx_addend1   = active ? b_byte : 8'h00;
        res_valid    = valid_q;
        res_sum      = sum_q;
        res_carry    = carry_q;
        res_zero     = zero_q;
    end

endmodule
